// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and sizing helpers for the memory port arbiter
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int DEFAULT_TIMEOUT = 15;

   // A disabled timeout (0) still needs a one-bit counter to stay a legal vector.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side and RAM-side signals of the shared memory port
interface mem_port_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_MASTERS   = 2
);
   logic [NUM_MASTERS-1:0]               REQ;
   logic [NUM_MASTERS-1:0]               WS;
   logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] ADDR;
   logic [NUM_MASTERS*DATA_WIDTH-1:0]    WDATA;
   logic [NUM_MASTERS-1:0]               ACK;
   logic [DATA_WIDTH-1:0]                RDATA;
   logic                                 ERR;
   logic [ADDRESS_WIDTH-1:0]             MEM_ADDR;
   logic [DATA_WIDTH-1:0]                MEM_WDATA;
   logic                                 MEM_WS;
   logic                                 MEM_OE;
   logic [DATA_WIDTH-1:0]                MEM_RDATA;
   logic                                 MEM_RDY;

   // master: the requesters together with the RAM; slave: the arbiter itself
   modport master (
      output REQ, WS, ADDR, WDATA, MEM_RDATA, MEM_RDY,
      input  ACK, RDATA, ERR, MEM_ADDR, MEM_WDATA, MEM_WS, MEM_OE
   );

   modport slave (
      input  REQ, WS, ADDR, WDATA, MEM_RDATA, MEM_RDY,
      output ACK, RDATA, ERR, MEM_ADDR, MEM_WDATA, MEM_WS, MEM_OE
   );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   int w_dist;
   int w_best;

   // The winner is the requester with the smallest forward distance from the pointer.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_dist  = 0;
      w_best  = N;
      for (int i = 0; i < N; i++) begin
         w_dist = (i + N - int'(i_ptr)) % N;
         if (i_req[i] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_idx   = IW'(i);
            o_valid = 1'b1;
         end
      end
      if (o_valid) begin
         o_grant[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin multi-master port onto a single wait-state RAM
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_MASTERS   = 2,
   parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
   input logic              CLK,
   input logic              RST,
   mem_port_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam int CW = cnt_width(TIMEOUT);

   state_t                   r_state;
   logic [IW-1:0]            r_ptr;
   logic [IW-1:0]            r_owner;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic                     r_ws;
   logic [CW-1:0]            r_cnt;
   logic [NUM_MASTERS-1:0]   r_ack;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic                     r_err;
   logic                     r_mem_ws;
   logic                     r_mem_oe;

   logic [NUM_MASTERS-1:0]   w_grant;
   logic [IW-1:0]            w_idx;
   logic                     w_valid;
   logic [ADDRESS_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0]    w_sel_wdata;
   logic                     w_sel_ws;
   logic                     w_timeout;
   logic [NUM_MASTERS-1:0]   w_owner_oh;
   logic [IW-1:0]            w_next_ptr;

   rr_arbiter #(.N(NUM_MASTERS)) u_rr (
      .i_req   (bus.REQ),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_sel_addr  = bus.ADDR[int'(w_idx) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign w_sel_wdata = bus.WDATA[int'(w_idx) * DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_ws    = |(bus.WS & w_grant);

   // r_cnt counts completed ACCESS cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
   assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
   assign w_owner_oh  = NUM_MASTERS'(1) << r_owner;
   assign w_next_ptr  = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ws     <= 1'b0;
         r_cnt    <= '0;
         r_ack    <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_mem_ws <= 1'b0;
         r_mem_oe <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_valid) begin
                  r_owner  <= w_idx;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_ws     <= w_sel_ws;
                  r_mem_ws <= w_sel_ws;
                  r_mem_oe <= ~w_sel_ws;
                  r_state  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_cnt <= r_cnt + 1'b1;
               // MEM_RDY takes precedence over a timeout landing in the same cycle.
               if (bus.MEM_RDY || w_timeout) begin
                  r_rdata  <= (bus.MEM_RDY && !r_ws) ? bus.MEM_RDATA : '0;
                  r_err    <= ~bus.MEM_RDY;
                  r_ack    <= w_owner_oh;
                  r_mem_ws <= 1'b0;
                  r_mem_oe <= 1'b0;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ack   <= '0;
               r_ptr   <= w_next_ptr;
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ACK       = r_ack;
   assign bus.RDATA     = r_rdata;
   assign bus.ERR       = r_err;
   assign bus.MEM_ADDR  = r_addr;
   assign bus.MEM_WDATA = r_wdata;
   assign bus.MEM_WS    = r_mem_ws;
   assign bus.MEM_OE    = r_mem_oe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level reference model
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NM = 2;
   localparam int TO = 4;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM)) bus ();

   mem_port_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .NUM_MASTERS   (NM),
      .TIMEOUT       (TO)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner -1 means no transaction in flight.
   int              m_owner  = -1;
   int              m_waited = 0;
   int              m_ptr    = 0;
   bit              m_acking = 1'b0;
   logic            m_ws     = 1'b0;
   logic [AW-1:0]   m_addr   = '0;
   logic [DW-1:0]   m_wdata  = '0;
   logic [NM-1:0]   e_ack    = '0;
   logic [DW-1:0]   e_rdata  = '0;
   logic            e_err    = 1'b0;
   logic            e_ws     = 1'b0;
   logic            e_oe     = 1'b0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_owner  <= -1;
         m_waited <= 0;
         m_ptr    <= 0;
         m_acking <= 1'b0;
         m_ws     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         e_ack    <= '0;
         e_rdata  <= '0;
         e_err    <= 1'b0;
         e_ws     <= 1'b0;
         e_oe     <= 1'b0;
      end else if (m_acking) begin
         m_ptr    <= (m_owner + 1) % NM;
         m_owner  <= -1;
         m_acking <= 1'b0;
         e_ack    <= '0;
      end else if (m_owner < 0) begin
         int w;
         w = -1;
         for (int k = 0; k < NM; k++)
            if (w < 0 && bus.REQ[(m_ptr + k) % NM]) w = (m_ptr + k) % NM;
         if (w >= 0) begin
            m_owner  <= w;
            m_waited <= 0;
            m_ws     <= bus.WS[w];
            m_addr   <= bus.ADDR[w*AW +: AW];
            m_wdata  <= bus.WDATA[w*DW +: DW];
            e_ws     <= bus.WS[w];
            e_oe     <= !bus.WS[w];
         end
      end else begin
         int waited;
         waited = m_waited + 1;
         m_waited <= waited;
         if (bus.MEM_RDY || (TO != 0 && waited == TO)) begin
            m_acking <= 1'b1;
            e_ack    <= NM'(1) << m_owner;
            e_err    <= !bus.MEM_RDY;
            e_rdata  <= (bus.MEM_RDY && !m_ws) ? bus.MEM_RDATA : '0;
            e_ws     <= 1'b0;
            e_oe     <= 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      chk("ack", bus.ACK, e_ack);
      chk("rdata", bus.RDATA, e_rdata);
      chk("err", bus.ERR, e_err);
      chk("mem_ws", bus.MEM_WS, e_ws);
      chk("mem_oe", bus.MEM_OE, e_oe);
      if (e_ws || e_oe) begin
         chk("mem_addr", bus.MEM_ADDR, m_addr);
         chk("mem_wdata", bus.MEM_WDATA, m_wdata);
      end
   end

   // Called at a negedge while the DUT is idle; cycle 1 is the first ACCESS cycle.
   task automatic do_access(input logic [NM-1:0] req, input logic [NM-1:0] ws,
                            input int rdy_at, input logic [DW-1:0] rdata,
                            output int cyc, output logic [NM-1:0] ack,
                            output int n_ws, output int n_oe,
                            output logic [AW-1:0] seen_addr, output logic [DW-1:0] seen_wdata);
      bus.REQ = req;
      bus.WS = ws;
      bus.MEM_RDATA = rdata;
      bus.MEM_RDY = 1'b0;
      cyc = 0;
      ack = '0;
      n_ws = 0;
      n_oe = 0;
      seen_addr = '0;
      seen_wdata = '0;
      while (ack == '0 && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (bus.MEM_WS) n_ws++;
         if (bus.MEM_OE) n_oe++;
         if (bus.MEM_WS || bus.MEM_OE) begin
            seen_addr = bus.MEM_ADDR;
            seen_wdata = bus.MEM_WDATA;
         end
         ack = bus.ACK;
         if (cyc == rdy_at) bus.MEM_RDY = 1'b1;
      end
      bus.REQ = '0;
      bus.WS = '0;
      bus.MEM_RDY = 1'b0;
      @(negedge CLK);
   endtask

   int            cyc, n_ws, n_oe, n_ack;
   logic [NM-1:0] ack;
   logic [NM-1:0] acks [3];
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   int            stray;

   initial begin
      bus.REQ = '0;
      bus.WS = '0;
      bus.ADDR = '0;
      bus.WDATA = '0;
      bus.MEM_RDATA = '0;
      bus.MEM_RDY = 1'b0;
      for (int i = 0; i < 3; i++) acks[i] = '0;
      repeat (3) @(negedge CLK);
      chk("reset_ack", bus.ACK, 0);
      chk("reset_rdata", bus.RDATA, 0);
      chk("reset_err", bus.ERR, 0);
      chk("reset_mem_addr", bus.MEM_ADDR, 0);
      chk("reset_mem_wdata", bus.MEM_WDATA, 0);
      chk("reset_ws_oe", {bus.MEM_WS, bus.MEM_OE}, 0);
      RST = 1'b1;
      @(negedge CLK);

      bus.ADDR = {32'h0, 32'h40};
      do_access(2'b01, 2'b00, 1, 32'hDEADBEEF, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("rd_latency", cyc, 2);
      chk("rd_ack", ack, 2'b01);
      chk("rd_rdata", bus.RDATA, 32'hDEADBEEF);
      chk("rd_err", bus.ERR, 0);
      chk("rd_oe_cycles", n_oe, 1);
      chk("rd_addr", s_addr, 32'h40);

      bus.ADDR = {32'h80, 32'h0};
      bus.WDATA = {32'h1234, 32'h0};
      do_access(2'b10, 2'b10, 4, 32'hFFFF_FFFF, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("wr_latency", cyc, 5);
      chk("wr_ack", ack, 2'b10);
      chk("wr_ws_cycles", n_ws, 4);
      chk("wr_oe_cycles", n_oe, 0);
      chk("wr_addr", s_addr, 32'h80);
      chk("wr_wdata", s_wdata, 32'h1234);
      chk("wr_rdata_zero", bus.RDATA, 0);
      chk("wr_err", bus.ERR, 0);

      bus.REQ = 2'b11;
      bus.WS = 2'b00;
      bus.MEM_RDY = 1'b1;
      bus.MEM_RDATA = 32'h55;
      n_ack = 0;
      cyc = 0;
      while (n_ack < 3 && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (bus.ACK != '0) begin
            acks[n_ack] = bus.ACK;
            n_ack++;
         end
      end
      bus.REQ = '0;
      bus.MEM_RDY = 1'b0;
      @(negedge CLK);
      chk("rr_count", n_ack, 3);
      chk("rr_ack0", acks[0], 2'b01);
      chk("rr_ack1", acks[1], 2'b10);
      chk("rr_ack2", acks[2], 2'b01);

      bus.ADDR = {32'h0, 32'h44};
      do_access(2'b01, 2'b00, 0, 32'hABCD, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("to_latency", cyc, 5);
      chk("to_ack", ack, 2'b01);
      chk("to_oe_cycles", n_oe, 4);
      chk("to_err", bus.ERR, 1);
      chk("to_rdata", bus.RDATA, 0);

      do_access(2'b01, 2'b00, 1, 32'h77, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("clr_err", bus.ERR, 0);
      chk("clr_rdata", bus.RDATA, 32'h77);

      do_access(2'b01, 2'b00, 4, 32'hCAFEF00D, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("tie_latency", cyc, 5);
      chk("tie_err", bus.ERR, 0);
      chk("tie_rdata", bus.RDATA, 32'hCAFEF00D);

      bus.ADDR = {32'h90, 32'h0};
      bus.REQ = 2'b10;
      bus.WS = 2'b10;
      bus.MEM_RDY = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_pre_ws", bus.MEM_WS, 1);
      #2 RST = 1'b0;
      #1;
      chk("rst_async_ws", bus.MEM_WS, 0);
      chk("rst_async_addr", bus.MEM_ADDR, 0);
      bus.REQ = '0;
      bus.WS = '0;
      @(negedge CLK);
      RST = 1'b1;
      stray = 0;
      repeat (4) begin
         @(negedge CLK);
         if (bus.ACK != '0) stray++;
      end
      chk("rst_no_ack", stray, 0);
      do_access(2'b11, 2'b00, 1, 32'h99, cyc, ack, n_ws, n_oe, s_addr, s_wdata);
      chk("rst_ptr_master0", ack, 2'b01);
      chk("rst_next_latency", cyc, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised multi-master memory port for the multi-cycle MIPS core family. The block lets NUM_MASTERS requesters (instruction/data port, EPC/exception logic, DMA) share one single-ported RAM that may insert wait states. It replaces the core's direct fixed-latency DATA/Addr/MEM_WS hookup with round-robin arbitration, a request/acknowledge handshake, variable memory latency and a bus-timeout error.

## Interface
- ADDRESS_WIDTH, 32, address width per master and to RAM
- DATA_WIDTH, 32, read/write data width
- NUM_MASTERS, 2, number of requesting channels (≥2)
- TIMEOUT, 15, maximum ACCESS cycles without MEM_RDY before an error; 0 disables the timeout

- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-low reset
- REQ  in  NUM_MASTERS  per-master access request
- WS  in  NUM_MASTERS  per-master write select (1 = write, 0 = read)
- ADDR  in  NUM_MASTERS*ADDRESS_WIDTH  packed addresses; master i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- WDATA  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing
- ACK  out  NUM_MASTERS  one-hot completion pulse to the owning master
- RDATA  out  DATA_WIDTH  read data, valid in the ACK cycle
- ERR  out  1  timeout flag, valid in the ACK cycle
- MEM_ADDR  out  ADDRESS_WIDTH  RAM address
- MEM_WDATA  out  DATA_WIDTH  RAM write data
- MEM_WS  out  1  RAM write strobe
- MEM_OE  out  1  RAM output enable
- MEM_RDATA  in  DATA_WIDTH  RAM read data
- MEM_RDY  in  1  RAM access complete

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any REQ bit is high, pick a winner by round-robin and latch owner, ADDR, WDATA and WS into registers. Go to ACCESS. Otherwise stay in IDLE.
- Round-robin: priority pointer resets to 0. The search starts at the pointer and wraps modulo NUM_MASTERS. After master k completes, the pointer becomes (k+1) mod NUM_MASTERS.
- ACCESS: MEM_ADDR and MEM_WDATA come from the latched values. MEM_WS equals the latched WS and MEM_OE equals its inverse; both are held for every ACCESS cycle. A wait counter increments each cycle.
  - MEM_RDY=1: capture MEM_RDATA into RDATA (writes capture 0), clear ERR, go to DONE.
  - Counter reaches TIMEOUT with MEM_RDY=0 (TIMEOUT≠0): set RDATA=0 and ERR=1, go to DONE.
  - MEM_RDY and timeout in the same cycle: MEM_RDY wins.
- DONE: ACK[owner]=1 for exactly one cycle. MEM_WS and MEM_OE are 0. Advance the pointer, return to IDLE.
- Masters hold REQ, WS, ADDR and WDATA until their ACK. A REQ dropped mid-access does not abort the access; ACK is still pulsed.
- RDATA and ERR keep their value until the next DONE.

## Timing
- Reset (RST=0, asynchronous): state IDLE, pointer 0. All outputs are 0: ACK, RDATA, ERR, MEM_ADDR, MEM_WDATA, MEM_WS, MEM_OE. The counter clears. An in-flight access is abandoned and its ACK never issues.
- Minimum latency: REQ seen in IDLE at cycle 0, ACCESS at cycle 1 with MEM_RDY=1, ACK at cycle 2. Each wait cycle adds one cycle.
- Maximum throughput is one access per 3 cycles. DONE always passes through IDLE.
- MEM_WS is never asserted outside ACCESS.
- A write whose ACCESS ends in timeout still drove MEM_WS for TIMEOUT cycles. The master discards the result based on ERR.

## Structure
- Shared package/include mips_mem_pkg holds:
  - state encodings IDLE/ACCESS/DONE
  - the default TIMEOUT
  - the counter-width function $clog2(TIMEOUT+1)
- Sub-module rr_arbiter (parameter N): combinational. Takes a request vector and the pointer; outputs a one-hot grant and the encoded index. Instantiated once.
- All remaining logic (FSM, latches, counter) lives in mem_port_arbiter.

## Test plan
- Single read, no waits: REQ=01, ADDR0=0x40, MEM_RDY=1 in the first ACCESS cycle, MEM_RDATA=0xDEADBEEF. Expect ACK=01 at cycle 2, RDATA=0xDEADBEEF, ERR=0, MEM_OE high for 1 cycle.
- Write with 3 wait states: REQ=10, WS=10, ADDR1=0x80, WDATA1=0x1234. Expect MEM_WS=1 with MEM_ADDR=0x80 and MEM_WDATA=0x1234 for 4 cycles, then ACK=10 at cycle 5.
- Contention and fairness: REQ=11 held continuously with NUM_MASTERS=2. Expect ACK alternating 01, 10, 01, and no master ACKed twice in a row.
- Timeout: TIMEOUT=4, MEM_RDY stuck at 0. Expect 4 ACCESS cycles, then ACK with ERR=1 and RDATA=0. The next access with MEM_RDY=1 clears ERR.
- Simultaneous MEM_RDY and timeout in the 4th ACCESS cycle: expect ERR=0 and RDATA=MEM_RDATA.
- Reset mid-ACCESS: assert RST=0 during a write wait state. Expect MEM_WS=0 immediately (asynchronously), no ACK after release, and a next grant that starts from master 0.
